// File: rtl/aes_decrypt_iter.sv
// ----------------------------------------------------------------------------
// aes_decrypt_iter
//
// Iterative AES inverse cipher: one 128-bit block in flight, one inverse round
// per clock through a single shared round datapath
// (InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns).
// NR selects AES-128/192/256 (10/12/14 rounds).
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   ciphertext present on in_data
//   in_ready   block is idle and will accept in_data
//   in_data    ciphertext, byte 0 in bits 127:120
//   rk_idx     round-key index requested this cycle (register-driven only)
//   rk         round key for rk_idx, supplied combinationally by the key store
//   out_valid  plaintext held on out_data
//   out_ready  sink accepts out_data
//   out_data   plaintext, registered
//   busy       rounds in progress (ROUND or FINAL)
// ----------------------------------------------------------------------------
module aes_decrypt_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_decrypt_iter: NR must be 10, 12 or 14");
  end

  // --------------------------------------------------------------------------
  // GF(2^8) helpers (AES polynomial x^8 + x^4 + x^3 + x + 1)
  // --------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply over 8'b1111_1110);
  // maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      p = gf_mul(p, p);
      if (i != 0) p = gf_mul(p, a);
    end
    return p;
  endfunction

  // Inverse S-box: undo the affine map first, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e       fsm_q;
  logic [3:0]   r_q;
  logic [127:0] blk_q;
  logic [127:0] out_data_q;
  logic         out_valid_q;

  // --------------------------------------------------------------------------
  // Shared inverse-round datapath
  // --------------------------------------------------------------------------
  logic [127:0] isr;          // after InvShiftRows
  logic [127:0] isb;          // after InvSubBytes
  logic [127:0] ark_d;        // after AddRoundKey (also the FINAL result)
  logic [127:0] imc_d;        // after InvMixColumns (ROUND result)

  // Byte gi sits at row gi%4, column gi/4. InvShiftRows rotates row r right
  // by r, so output byte (r,c) is taken from input byte (r,(c-r) mod 4).
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int SRC = ROW + 4 * (((gi / 4) - ROW + 4) % 4);
    assign isr[127-8*gi -: 8] = blk_q[127-8*SRC -: 8];
    assign isb[127-8*gi -: 8] = inv_sbox(isr[127-8*gi -: 8]);
  end

  assign ark_d = isb ^ rk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark_d[127-32*gi -: 8];
    assign a1 = ark_d[119-32*gi -: 8];
    assign a2 = ark_d[111-32*gi -: 8];
    assign a3 = ark_d[103-32*gi -: 8];
    assign imc_d[127-32*gi -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                                   gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign imc_d[119-32*gi -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                                   gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign imc_d[111-32*gi -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                                   gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign imc_d[103-32*gi -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                                   gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= S_IDLE;
      r_q         <= 4'd0;
      blk_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          // rk_idx is NR here, so rk is the whitening key.
          if (in_valid) begin
            blk_q <= in_data ^ rk;
            r_q   <= 4'(NR - 1);
            fsm_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          blk_q <= imc_d;
          r_q   <= r_q - 4'd1;
          if (r_q == 4'd1) fsm_q <= S_FINAL;
        end
        S_FINAL: begin
          out_data_q  <= ark_d;
          out_valid_q <= 1'b1;
          fsm_q       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            fsm_q       <= S_IDLE;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  // Key index decodes from registers only; IDLE and DONE both present NR so
  // the whitening key is already on rk when the next block arrives.
  always_comb begin
    rk_idx = 4'(NR);
    case (fsm_q)
      S_ROUND: rk_idx = r_q;
      S_FINAL: rk_idx = 4'd0;
      default: rk_idx = 4'(NR);
    endcase
  end

  assign in_ready  = (fsm_q == S_IDLE);
  assign busy      = (fsm_q == S_ROUND) || (fsm_q == S_FINAL);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
